muldiv_unit: RTL and testbench

- Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU. It owns the architectural HI/LO registers.
- Operands come straight from the register file read ports (rs → r1, rt → r2).
- HI/LO go back to the register-file write-data mux for MFHI/MFLO.
- While an operation runs, `busy` stalls the core; MTHI/MTLO write HI/LO directly.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_unit.sv | 186 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and defaults for the multiply/divide unit
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI/LO
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;      // 1: divide, 0: multiply
  logic [WIDTH-1:0] b_q, b_d;          // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0] rem_q, rem_d;      // product high half / partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;      // multiplier bits / dividend-then-quotient
  logic [WIDTH-1:0] rs_raw_q, rs_raw_d; // original dividend, returned on divide by zero
  logic             neg_q, neg_d;      // negate product or quotient
  logic             rneg_q, rneg_d;    // negate remainder
  logic             dz_q, dz_d;        // divisor was zero
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             sgn, rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and HI/LO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      div_q    <= 1'b0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      rs_raw_q <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      rs_raw_q <= rs_raw_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  // Next-state, one iteration step per RUN cycle, sign fix-up in FIX
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    b_d       = b_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    rs_raw_d  = rs_raw_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    sgn       = (op == OP_MULT) || (op == OP_DIV);
    rs_neg    = sgn & rs_val[WIDTH-1];
    rt_neg    = sgn & rt_val[WIDTH-1];
    rs_mag    = rs_neg ? (~rs_val + 1'b1) : rs_val;
    rt_mag    = rt_neg ? (~rt_val + 1'b1) : rt_val;
    mul_sum   = '0;
    div_shift = '0;
    div_ge    = 1'b0;
    prod      = '0;

    case (state_q)
      IDLE: begin
        // Direct HI/LO writes only land while idle; a start on the same edge
        // will overwrite them with its result later.
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          state_d  = RUN;
          cnt_d    = '0;
          div_d    = op[1];
          rem_d    = '0;
          rs_raw_d = rs_val;
          neg_d    = rs_neg ^ rt_neg;
          rneg_d   = rs_neg;
          dz_d     = (rt_val == '0);
          if (op[1]) begin
            b_d   = rt_mag;
            quo_d = rs_mag;
          end else begin
            b_d   = rs_mag;
            quo_d = rt_mag;
          end
        end
      end

      RUN: begin
        if (!div_q) begin
          // Right-shifting shift-add: {rem,quo} converges to the product.
          mul_sum = {1'b0, rem_q} + (quo_q[0] ? {1'b0, b_q} : '0);
          rem_d   = mul_sum[WIDTH:1];
          quo_d   = {mul_sum[0], quo_q[WIDTH-1:1]};
        end else begin
          // Restoring division: shift in the next dividend bit, subtract if it fits.
          div_shift = {rem_q, quo_q[WIDTH-1]};
          div_ge    = (div_shift >= {1'b0, b_q});
          if (div_ge) begin
            rem_d = WIDTH'(div_shift - {1'b0, b_q});
          end else begin
            rem_d = div_shift[WIDTH-1:0];
          end
          quo_d = {quo_q[WIDTH-2:0], div_ge};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) state_d = FIX;
      end

      FIX: begin
        if (div_q) begin
          if (dz_q) begin
            hi_d = rs_raw_q;
            lo_d = '1;
          end else begin
            lo_d = neg_q  ? (~quo_q + 1'b1) : quo_q;
            hi_d = rneg_q ? (~rem_q + 1'b1) : rem_q;
          end
        end else begin
          prod = {rem_q, quo_q};
          if (neg_q) prod = ~prod + 1'b1;
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] rh, rl;
  int          lat, bc;

  muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic with the architectural rules
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] ehi, output logic [31:0] elo);
    longint sa, sb, p, q, r;
    bit     signed_op;
    signed_op = (o == 2'b00) || (o == 2'b10);
    sa = signed_op ? longint'({{32{a[31]}}, a}) : longint'({32'b0, a});
    sb = signed_op ? longint'({{32{b[31]}}, b}) : longint'({32'b0, b});
    if (o[1] == 1'b0) begin
      p   = sa * sb;
      ehi = p[63:32];
      elo = p[31:0];
    end else if (b == 32'h0) begin
      ehi = a;
      elo = 32'hFFFF_FFFF;
    end else begin
      q   = sa / sb;
      r   = sa % sb;
      ehi = r[31:0];
      elo = q[31:0];
    end
  endfunction

  // Issue an operation at the current negedge; return at the negedge where done is seen
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] oh, output logic [31:0] ol,
                        output int olat, output int obusy);
    int k;
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0; rs_val = $urandom; rt_val = $urandom; op = 2'($urandom_range(0, 3));
    k = 0; obusy = 0;
    while (!done && k < 100) begin
      if (busy) obusy++;
      @(negedge clk);
      k++;
    end
    olat = k; oh = hi; ol = lo;
    n_cmp++;
    if (k >= 100) begin
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles, required done at 33", k);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", done); end
    n_cmp++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h required 0", hi); end
    n_cmp++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h required 0", lo); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_multu_max();
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rh, rl, lat, bc);
    n_cmp++; if (rh !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_max_hi: got %h required fffffffe", rh); end
    n_cmp++; if (rl !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_max_lo: got %h required 00000001", rl); end
    n_cmp++; if (lat != 33) begin n_fail++; $display("FAIL multu_latency: got %0d required 33", lat); end
    n_cmp++; if (bc != 33) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d required 33", bc); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: got %b required 0", done); end
  endtask

  task automatic test_back_to_back();
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, rh, rl, lat, bc);
    n_cmp++; if (rh !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_neg_hi: got %h required ffffffff", rh); end
    n_cmp++; if (rl !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_neg_lo: got %h required ffffffeb", rl); end
    run_op(2'b11, 32'd100, 32'd7, rh, rl, lat, bc);
    n_cmp++; if (rl !== 32'h0000_000E) begin n_fail++; $display("FAIL b2b_divu_lo: got %h required 0000000e", rl); end
    n_cmp++; if (rh !== 32'h0000_0002) begin n_fail++; $display("FAIL b2b_divu_hi: got %h required 00000002", rh); end
    n_cmp++; if (lat != 33) begin n_fail++; $display("FAIL b2b_latency: got %0d required 33", lat); end
  endtask

  task automatic test_div_signed();
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, rh, rl, lat, bc);
    n_cmp++; if (rl !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_lo: got %h required fffffffd", rl); end
    n_cmp++; if (rh !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_hi: got %h required ffffffff", rh); end
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, rh, rl, lat, bc);
    n_cmp++; if (rl !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo: got %h required 80000000", rl); end
    n_cmp++; if (rh !== 32'h0000_0000) begin n_fail++; $display("FAIL div_ovf_hi: got %h required 00000000", rh); end
  endtask

  task automatic test_div_zero();
    run_op(2'b11, 32'h0000_0064, 32'h0, rh, rl, lat, bc);
    n_cmp++; if (rh !== 32'h0000_0064) begin n_fail++; $display("FAIL divu_zero_hi: got %h required 00000064", rh); end
    n_cmp++; if (rl !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_zero_lo: got %h required ffffffff", rl); end
    n_cmp++; if (lat != 33) begin n_fail++; $display("FAIL divu_zero_latency: got %0d required 33", lat); end
    run_op(2'b10, 32'hFFFF_FF00, 32'h0, rh, rl, lat, bc);
    n_cmp++; if (rh !== 32'hFFFF_FF00) begin n_fail++; $display("FAIL div_zero_hi: got %h required ffffff00", rh); end
    n_cmp++; if (rl !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_zero_lo: got %h required ffffffff", rl); end
  endtask

  task automatic test_ignore_while_busy();
    int k;
    start = 1'b1; op = 2'b01; rs_val = 32'd2; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 100) begin
      if (k == 4) begin start = 1'b1; op = 2'b10; rs_val = 32'd9; rt_val = 32'd3; end
      if (k == 5) begin start = 1'b0; hi_we = 1'b1; wdata = 32'hDEAD_BEEF; end
      if (k == 6) hi_we = 1'b0;
      @(negedge clk);
      k++;
    end
    n_cmp++; if (k != 33) begin n_fail++; $display("FAIL ignore_latency: got %0d required 33", k); end
    n_cmp++; if (hi !== 32'h0) begin n_fail++; $display("FAIL ignore_hi: got %h required 00000000", hi); end
    n_cmp++; if (lo !== 32'd6) begin n_fail++; $display("FAIL ignore_lo: got %h required 00000006", lo); end
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    lo_we = 1'b0;
    n_cmp++; if (lo !== 32'h1234_5678) begin n_fail++; $display("FAIL mtlo: got %h required 12345678", lo); end
    n_cmp++; if (hi !== 32'h0) begin n_fail++; $display("FAIL mtlo_hi_kept: got %h required 00000000", hi); end
    hi_we = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    hi_we = 1'b0;
    n_cmp++; if (hi !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL mthi: got %h required cafef00d", hi); end
  endtask

  task automatic test_reset_mid_op();
    start = 1'b1; op = 2'b00; rs_val = 32'h1234_5678; rt_val = 32'h8765_4321;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b required 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b required 0", done); end
    n_cmp++; if (hi !== 32'h0) begin n_fail++; $display("FAIL midrst_hi: got %h required 0", hi); end
    n_cmp++; if (lo !== 32'h0) begin n_fail++; $display("FAIL midrst_lo: got %h required 0", lo); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(2'b01, 32'd4, 32'd5, rh, rl, lat, bc);
    n_cmp++; if (rl !== 32'h14) begin n_fail++; $display("FAIL post_rst_lo: got %h required 00000014", rl); end
    n_cmp++; if (rh !== 32'h0) begin n_fail++; $display("FAIL post_rst_hi: got %h required 00000000", rh); end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b, ehi, elo;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case (i % 6)
        5:       b = 32'h0;
        1, 3:    b = (($urandom & 1) != 0) ? -32'($urandom_range(1, 20)) : 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      model(o, a, b, ehi, elo);
      run_op(o, a, b, rh, rl, lat, bc);
      n_cmp++; if (rh !== ehi) begin n_fail++; $display("FAIL rand_hi[%0d] op=%0d a=%h b=%h: got %h required %h", i, o, a, b, rh, ehi); end
      n_cmp++; if (rl !== elo) begin n_fail++; $display("FAIL rand_lo[%0d] op=%0d a=%h b=%h: got %h required %h", i, o, a, b, rl, elo); end
      n_cmp++; if (lat != 33) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d required 33", i, lat); end
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_back_to_back();
    test_div_signed();
    test_div_zero();
    test_ignore_while_busy();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
